// File: rtl/tod_counter_bcd.sv
// Time-of-day counter for the wristwatch datapath.
// Keeps hh/mm/ss in binary 24 h form, advances on a 1 Hz strobe, supports a
// set mode with hour/minute stepping, and drives registered BCD digits in
// 12 h or 24 h format plus day-carry and alarm-match pulses.
// Digits and pulses trail the counter registers by one clock.
module tod_counter_bcd #(
    parameter logic [4:0] RESET_HH       = 5'd0,
    parameter logic [5:0] RESET_MM       = 6'd0,
    parameter logic [5:0] RESET_SS       = 6'd0,
    parameter bit         SET_CLEARS_SEC = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       mode_12h,
    input  logic       set_mode,
    input  logic       set_hr_inc,
    input  logic       set_min_inc,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hh,
    input  logic [5:0] alarm_mm,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [3:0] hr_ones,
    output logic [3:0] hr_tens,
    output logic       pm,
    output logic       day_pulse,
    output logic       alarm_hit
);

    // Binary 0-59 to two BCD digits {tens, ones} by compare/subtract.
    // The ones digit is always below 16, so subtracting (10*k mod 16) from the
    // low nibble gives the exact result without a full-width subtractor.
    function automatic logic [7:0] bin_to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        if (v >= 6'd60) begin
            tens = 4'd0;
            ones = 4'd0;
        end else if (v >= 6'd50) begin
            tens = 4'd5;
            ones = v[3:0] - 4'd2;
        end else if (v >= 6'd40) begin
            tens = 4'd4;
            ones = v[3:0] - 4'd8;
        end else if (v >= 6'd30) begin
            tens = 4'd3;
            ones = v[3:0] - 4'd14;
        end else if (v >= 6'd20) begin
            tens = 4'd2;
            ones = v[3:0] - 4'd4;
        end else if (v >= 6'd10) begin
            tens = 4'd1;
            ones = v[3:0] - 4'd10;
        end else begin
            tens = 4'd0;
            ones = v[3:0];
        end
        return {tens, ones};
    endfunction

    // Displayed hour: identity in 24 h mode, 12/1..12/1..11 mapping in 12 h mode.
    function automatic logic [4:0] hour_disp(input logic [4:0] h, input logic m12);
        logic [4:0] d;
        if (!m12) begin
            d = h;
        end else if (h == 5'd0) begin
            d = 5'd12;
        end else if (h > 5'd12) begin
            d = h - 5'd12;
        end else begin
            d = h;
        end
        return d;
    endfunction

    // Out-of-range reset parameters fall back to zero so counters stay legal.
    localparam logic [4:0] RST_HH = (RESET_HH > 5'd23) ? 5'd0 : RESET_HH;
    localparam logic [5:0] RST_MM = (RESET_MM > 6'd59) ? 6'd0 : RESET_MM;
    localparam logic [5:0] RST_SS = (RESET_SS > 6'd59) ? 6'd0 : RESET_SS;
    localparam logic [7:0] RST_HR_BCD  = bin_to_bcd({1'b0, RST_HH});
    localparam logic [7:0] RST_MIN_BCD = bin_to_bcd(RST_MM);
    localparam logic [7:0] RST_SEC_BCD = bin_to_bcd(RST_SS);
    localparam logic       RST_PM      = (RST_HH >= 5'd12);

    logic [4:0] hh_r;
    logic [5:0] mm_r;
    logic [5:0] ss_r;
    logic [4:0] hh_nxt_s;
    logic [5:0] mm_nxt_s;
    logic [5:0] ss_nxt_s;
    logic       day_evt_s;
    logic       alarm_evt_s;
    logic       day_evt_r;
    logic       alarm_evt_r;
    logic [7:0] hr_bcd_s;
    logic [7:0] min_bcd_s;
    logic [7:0] sec_bcd_s;

    // Next-state: set-mode editing has priority over tick-driven counting.
    always_comb begin
        hh_nxt_s    = hh_r;
        mm_nxt_s    = mm_r;
        ss_nxt_s    = ss_r;
        day_evt_s   = 1'b0;
        alarm_evt_s = 1'b0;
        if (set_mode) begin
            if (set_min_inc) begin
                mm_nxt_s = (mm_r == 6'd59) ? 6'd0 : (mm_r + 6'd1);
            end else begin
                mm_nxt_s = mm_r;
            end
            if (set_hr_inc) begin
                hh_nxt_s = (hh_r == 5'd23) ? 5'd0 : (hh_r + 5'd1);
            end else begin
                hh_nxt_s = hh_r;
            end
            if (SET_CLEARS_SEC) begin
                ss_nxt_s = 6'd0;
            end else begin
                ss_nxt_s = ss_r;
            end
        end else if (tick_1hz) begin
            if (ss_r == 6'd59) begin
                ss_nxt_s = 6'd0;
                if (mm_r == 6'd59) begin
                    mm_nxt_s = 6'd0;
                    if (hh_r == 5'd23) begin
                        hh_nxt_s  = 5'd0;
                        day_evt_s = 1'b1;
                    end else begin
                        hh_nxt_s = hh_r + 5'd1;
                    end
                end else begin
                    mm_nxt_s = mm_r + 6'd1;
                end
                // Only a tick into ss=0 can match; alarm values above 23/59 never equal a legal count.
                alarm_evt_s = alarm_en && (hh_nxt_s == alarm_hh) && (mm_nxt_s == alarm_mm);
            end else begin
                ss_nxt_s = ss_r + 6'd1;
            end
        end else begin
            hh_nxt_s = hh_r;
        end
    end

    // Time counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hh_r <= RST_HH;
            mm_r <= RST_MM;
            ss_r <= RST_SS;
        end else begin
            hh_r <= hh_nxt_s;
            mm_r <= mm_nxt_s;
            ss_r <= ss_nxt_s;
        end
    end

    // Event flags captured alongside the counter update, presented one clock later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day_evt_r   <= 1'b0;
            alarm_evt_r <= 1'b0;
        end else begin
            day_evt_r   <= day_evt_s;
            alarm_evt_r <= alarm_evt_s;
        end
    end

    // Display conversion of the current counter state.
    always_comb begin
        hr_bcd_s  = bin_to_bcd({1'b0, hour_disp(hh_r, mode_12h)});
        min_bcd_s = bin_to_bcd(mm_r);
        sec_bcd_s = bin_to_bcd(ss_r);
    end

    // Registered display digits and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hr_tens   <= RST_HR_BCD[7:4];
            hr_ones   <= RST_HR_BCD[3:0];
            min_tens  <= RST_MIN_BCD[7:4];
            min_ones  <= RST_MIN_BCD[3:0];
            sec_tens  <= RST_SEC_BCD[7:4];
            sec_ones  <= RST_SEC_BCD[3:0];
            pm        <= RST_PM;
            day_pulse <= 1'b0;
            alarm_hit <= 1'b0;
        end else begin
            hr_tens   <= hr_bcd_s[7:4];
            hr_ones   <= hr_bcd_s[3:0];
            min_tens  <= min_bcd_s[7:4];
            min_ones  <= min_bcd_s[3:0];
            sec_tens  <= sec_bcd_s[7:4];
            sec_ones  <= sec_bcd_s[3:0];
            pm        <= (hh_r >= 5'd12);
            day_pulse <= day_evt_r;
            alarm_hit <= alarm_evt_r;
        end
    end

endmodule

// File: tb/tb_tod_counter_bcd.sv
// Directed self-checking bench for tod_counter_bcd.
// Two instances share stimulus: u_dut with default reset time, u_pre preloaded to 23:59:58.
module tb_tod_counter_bcd;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       mode_12h = 1'b0;
    logic       set_mode = 1'b0;
    logic       set_hr_inc = 1'b0;
    logic       set_min_inc = 1'b0;
    logic       alarm_en = 1'b0;
    logic [4:0] alarm_hh = 5'd0;
    logic [5:0] alarm_mm = 6'd0;

    logic [3:0] s1_0, s10_0, m1_0, m10_0, h1_0, h10_0;
    logic       pm_0, day_0, alm_0;
    logic [3:0] s1_1, s10_1, m1_1, m10_1, h1_1, h10_1;
    logic       pm_1, day_1, alm_1;

    logic [23:0] dig_0;
    logic [23:0] dig_1;
    assign dig_0 = {h10_0, h1_0, m10_0, m1_0, s10_0, s1_0};
    assign dig_1 = {h10_1, h1_1, m10_1, m1_1, s10_1, s1_1};

    int checks = 0;
    int errors = 0;
    int day0_cnt = 0;
    int day1_cnt = 0;
    int alm0_cnt = 0;
    int alm_base = 0;

    tod_counter_bcd u_dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .mode_12h(mode_12h),
        .set_mode(set_mode), .set_hr_inc(set_hr_inc), .set_min_inc(set_min_inc),
        .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
        .sec_ones(s1_0), .sec_tens(s10_0), .min_ones(m1_0), .min_tens(m10_0),
        .hr_ones(h1_0), .hr_tens(h10_0), .pm(pm_0), .day_pulse(day_0), .alarm_hit(alm_0)
    );

    tod_counter_bcd #(.RESET_HH(5'd23), .RESET_MM(6'd59), .RESET_SS(6'd58), .SET_CLEARS_SEC(1'b1)) u_pre (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .mode_12h(mode_12h),
        .set_mode(set_mode), .set_hr_inc(set_hr_inc), .set_min_inc(set_min_inc),
        .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
        .sec_ones(s1_1), .sec_tens(s10_1), .min_ones(m1_1), .min_tens(m10_1),
        .hr_ones(h1_1), .hr_tens(h10_1), .pm(pm_1), .day_pulse(day_1), .alarm_hit(alm_1)
    );

    // Free-running clock, posedges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (day_0 === 1'b1) day0_cnt <= day0_cnt + 1;
        if (day_1 === 1'b1) day1_cnt <= day1_cnt + 1;
        if (alm_0 === 1'b1) alm0_cnt <= alm0_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic ticks(input int n);
        tick_1hz = 1'b1;
        steps(n);
        tick_1hz = 1'b0;
    endtask

    task automatic pulse_hr(input int n);
        for (int i = 0; i < n; i++) begin
            set_hr_inc = 1'b1;
            step();
            set_hr_inc = 1'b0;
        end
    endtask

    task automatic pulse_min(input int n);
        for (int i = 0; i < n; i++) begin
            set_min_inc = 1'b1;
            step();
            set_min_inc = 1'b0;
        end
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        #10;
        check_val("rst_dig0", 32'(dig_0), 32'h000000);
        check_val("rst_pm0", 32'(pm_0), 32'h0);
        check_val("rst_day0", 32'(day_0), 32'h0);
        check_val("rst_alm0", 32'(alm_0), 32'h0);
        check_val("rst_dig1", 32'(dig_1), 32'h235958);
        check_val("rst_pm1", 32'(pm_1), 32'h1);
        step();
        rst_n = 1'b1;
        step();
        check_val("idle_dig0", 32'(dig_0), 32'h000000);

        // Three consecutive ticks; preloaded instance rolls over midnight
        tick_1hz = 1'b1;
        step();
        step();
        check_val("pre_2359", 32'(dig_1), 32'h235959);
        check_val("pre_noday", 32'(day_1), 32'h0);
        step();
        tick_1hz = 1'b0;
        check_val("lat_dig0", 32'(dig_0), 32'h000002);
        check_val("pre_mid", 32'(dig_1), 32'h000000);
        check_val("pre_day", 32'(day_1), 32'h1);
        check_val("pre_pm0", 32'(pm_1), 32'h0);
        step();
        check_val("cnt3_dig0", 32'(dig_0), 32'h000003);
        check_val("cnt3_pm0", 32'(pm_0), 32'h0);
        check_val("pre_dayoff", 32'(day_1), 32'h0);
        step();
        check_val("pre_daycnt", 32'(day1_cnt), 32'd1);
        check_val("dut_daycnt", 32'(day0_cnt), 32'd0);

        // 12 h display
        mode_12h = 1'b1;
        step();
        check_val("h12_h0", 32'(dig_0), 32'h120003);
        check_val("h12_pm0", 32'(pm_0), 32'h0);
        set_mode = 1'b1;
        pulse_hr(13);
        steps(2);
        check_val("h12_h13", 32'(dig_0), 32'h010000);
        check_val("h12_pm13", 32'(pm_0), 32'h1);
        pulse_hr(23);
        steps(2);
        check_val("h12_h12", 32'(dig_0), 32'h120000);
        check_val("h12_pm12", 32'(pm_0), 32'h1);

        // Hour wrap in set mode gives no day pulse
        mode_12h = 1'b0;
        pulse_hr(11);
        steps(2);
        check_val("set_h23", 32'(dig_0), 32'h230000);
        pulse_hr(1);
        steps(2);
        check_val("set_hwrap", 32'(dig_0), 32'h000000);
        check_val("set_noday0", 32'(day0_cnt), 32'd0);
        check_val("set_noday1", 32'(day1_cnt), 32'd1);

        // Reach 10:59:30, then enter set mode with tick and minute step together
        pulse_hr(10);
        pulse_min(59);
        set_mode = 1'b0;
        ticks(30);
        steps(2);
        check_val("t105930", 32'(dig_0), 32'h105930);
        set_mode = 1'b1;
        tick_1hz = 1'b1;
        set_min_inc = 1'b1;
        step();
        tick_1hz = 1'b0;
        set_min_inc = 1'b0;
        step();
        check_val("set_min_wrap", 32'(dig_0), 32'h100000);
        ticks(5);
        step();
        check_val("set_hold", 32'(dig_0), 32'h100000);
        check_val("set_noday", 32'(day0_cnt), 32'd0);
        set_mode = 1'b0;
        step();
        check_val("exit_hold", 32'(dig_0), 32'h100000);
        ticks(1);
        step();
        check_val("exit_count", 32'(dig_0), 32'h100001);

        // Alarm 07:30
        alarm_hh = 5'd7;
        alarm_mm = 6'd30;
        alarm_en = 1'b1;
        set_mode = 1'b1;
        pulse_hr(21);
        pulse_min(29);
        set_mode = 1'b0;
        ticks(59);
        steps(2);
        check_val("t072959", 32'(dig_0), 32'h072959);
        alm_base = alm0_cnt;
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        check_val("alm_lat", 32'(alm_0), 32'h0);
        step();
        check_val("alm_hit", 32'(alm_0), 32'h1);
        check_val("alm_dig", 32'(dig_0), 32'h073000);
        step();
        check_val("alm_off", 32'(alm_0), 32'h0);
        step();
        check_val("alm_once", 32'(alm0_cnt), 32'(alm_base + 1));

        // Same crossing with alarm disabled
        set_mode = 1'b1;
        pulse_min(59);
        set_mode = 1'b0;
        alarm_en = 1'b0;
        ticks(60);
        steps(3);
        check_val("alm_dis_dig", 32'(dig_0), 32'h073000);
        check_val("alm_dis", 32'(alm0_cnt), 32'(alm_base + 1));

        // Setting the time onto the alarm in set mode
        alarm_en = 1'b1;
        set_mode = 1'b1;
        pulse_min(59);
        pulse_min(1);
        steps(3);
        check_val("alm_set_dig", 32'(dig_0), 32'h073000);
        check_val("alm_set", 32'(alm0_cnt), 32'(alm_base + 1));

        // Reach 12:34:56; last tick arrives with a stray minute step outside set mode
        pulse_hr(5);
        pulse_min(4);
        set_mode = 1'b0;
        ticks(55);
        tick_1hz = 1'b1;
        set_min_inc = 1'b1;
        step();
        tick_1hz = 1'b0;
        set_min_inc = 1'b0;
        steps(2);
        check_val("t123456", 32'(dig_0), 32'h123456);
        check_val("pm_123456", 32'(pm_0), 32'h1);

        // Asynchronous reset between clock edges
        #3 rst_n = 1'b0;
        #1;
        check_val("arst_dig0", 32'(dig_0), 32'h000000);
        check_val("arst_pm0", 32'(pm_0), 32'h0);
        check_val("arst_alm0", 32'(alm_0), 32'h0);
        check_val("arst_dig1", 32'(dig_1), 32'h235958);
        check_val("arst_pm1", 32'(pm_1), 32'h1);
        #1 rst_n = 1'b1;
        steps(2);
        check_val("post_rst", 32'(dig_0), 32'h000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tod_counter_bcd.md
Name: tod_counter_bcd

Overview:
Parametrised time-of-day counter for the wristwatch datapath. It keeps hours, minutes and seconds in binary 24 h form, advances on a one-cycle 1 Hz strobe, and supports a user set mode with independent hour/minute stepping. It drives six registered BCD digits in 12 h or 24 h format to the seven-segment display driver, plus a day-carry pulse and a minute-resolution alarm match.

Parameters:
RESET_HH, 0, hour loaded on reset (0-23, binary)
RESET_MM, 0, minute loaded on reset (0-59)
RESET_SS, 0, second loaded on reset (0-59)
SET_CLEARS_SEC, 1, 1 = seconds forced to 0 while set_mode=1; 0 = seconds frozen at current value

Ports:
clk  in  1  system clock; all flops on posedge
rst_n  in  1  reset, asynchronous assert, active-low
tick_1hz  in  1  one-clk-wide strobe, once per second, from divider
mode_12h  in  1  1 = 12 h display, 0 = 24 h display
set_mode  in  1  1 = time-set mode; counting halted
set_hr_inc  in  1  one-clk pulse (debounced upstream): hour +1
set_min_inc  in  1  one-clk pulse: minute +1
alarm_en  in  1  alarm compare enable
alarm_hh  in  5  alarm hour, binary 0-23
alarm_mm  in  6  alarm minute, binary 0-59
sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens  out  4 each  BCD display digits
pm  out  1  1 when internal hour >= 12 (both modes)
day_pulse  out  1  one-clk pulse on midnight rollover
alarm_hit  out  1  one-clk pulse on alarm match

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). Reset: hh/mm/ss = RESET_HH/MM/SS; digits = BCD of reset time in 24 h format; pm = (RESET_HH>=12); day_pulse = alarm_hit = 0.
- First clk edge after rst_n release: digits reflect mode_12h.
- Count (set_mode=0, tick_1hz=1): ss+1; ss 59->0 carries mm+1; mm 59->0 carries hh+1; hh 23->0. set_*_inc ignored when set_mode=0.
- Set (set_mode=1): tick_1hz ignored. set_min_inc: mm+1, 59->0, no carry into hh. set_hr_inc: hh+1, 23->0. Both in the same cycle: both apply. Seconds per SET_CLEARS_SEC. Leaving set mode: counting resumes on the next tick; no partial second is preserved.
- set_mode rising and tick in the same cycle: set_mode wins, tick dropped.
- Latency: counter registers update at edge N; digits, pm, day_pulse and alarm_hit update at edge N+1. mode_12h changes affect digits one edge later, with no counter change.
- Display conversion: 24 h: hr = hh. 12 h: hh=0 -> 12; 1-11 -> hh; 12 -> 12; 13-23 -> hh-12. Leading zeros are emitted as 0; blanking belongs to the display driver. Each digit is always 0-9, and tens digits are at most 5 for min/sec and at most 2 for hr.
- day_pulse: only on a tick-driven 23:59:59 -> 00:00:00. Hour wrap in set mode produces no pulse.
- alarm_hit: only on a tick-driven transition into ss=0 where alarm_en=1, hh=alarm_hh and mm=alarm_mm. Set-mode edits never fire it. Out-of-range alarm values never match.
- Reset mid-count: immediate return to reset values, and any pending pulse is cleared.
- Internal counters never hold out-of-range values. Widths: hh 5 b, mm 6 b, ss 6 b. BCD split is by compare/subtract, so no divider is needed.

Test Plan:
- Reset with defaults, then release and apply 3 ticks -> digits read 00:00:03 two edges after the third tick; pm=0.
- Preload 23:59:58 via parameters and apply 2 ticks -> 23:59:59, then 00:00:00; day_pulse high for exactly one clk; digits all 0.
- mode_12h=1: at hh=0, hr digits = 1,2 and pm=0; at hh=13, hr digits = 0,1 and pm=1; at hh=12, hr digits = 1,2 and pm=1.
- set_mode=1 at 10:59:30 with SET_CLEARS_SEC=1, set_min_inc pulse, ticks ongoing -> 10:00:00; hour unchanged; no counting; no day_pulse. set_hr_inc from hh=23 -> 0 with no day_pulse.
- Alarm 07:30, alarm_en=1, time 07:29:59 + tick -> alarm_hit one clk. Repeat with alarm_en=0 -> no pulse. Setting the time to 07:30 in set mode -> no pulse.
- rst_n pulsed low asynchronously between clk edges at 12:34:56 -> outputs return to reset values before the next clk edge; tick and set_min_inc in the same cycle with set_mode=0 -> only the tick takes effect.
